// File: rtl/program_memory.sv
// program_memory: word-addressed memory with registered fetch port and byte-serial loader
module program_memory #(
  parameter int    WORDS     = 256,
  parameter int    ADDR_BITS = 8,
  parameter string INIT_FILE = ""
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [31:0]          memory_address,
  input  logic                 memory_read_strobe,
  output logic [31:0]          memory_read_data,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic                 load_last,
  input  logic [7:0]           load_byte,
  output logic                 load_ready,
  output logic                 load_busy,
  output logic [ADDR_BITS:0]   load_word_count,
  output logic                 read_out_of_range,
  output logic                 load_overflow
);
  typedef enum logic [1:0] {L_IDLE, L_COLLECT, L_WRITE} l_state_t;
  localparam logic [ADDR_BITS:0] max_words = (ADDR_BITS+1)'(WORDS);
  l_state_t state, state_n;
  logic [31:0] mem [WORDS];
  logic [31:0] buffer;
  logic [1:0] byte_idx;
  logic [ADDR_BITS:0] wr_addr;
  logic last_seen, accept, wr_in_range, rd_in_range;
  assign accept = state == L_COLLECT && load_valid;
  assign wr_in_range = wr_addr < max_words;
  assign rd_in_range = memory_address < 32'(WORDS);
  assign load_word_count = wr_addr;
  always_ff @(posedge CLK)
    if (reset) state <= L_IDLE;
    else state <= state_n;
  always_comb begin
    load_ready = state == L_COLLECT;
    load_busy = state != L_IDLE;
    state_n = state == L_IDLE ? (load_start ? L_COLLECT : L_IDLE) :
              state == L_COLLECT ? (accept && (byte_idx == 2'd3 || load_last) ? L_WRITE : L_COLLECT) :
              (last_seen ? L_IDLE : L_COLLECT);
  end
  always_ff @(posedge CLK)
    if (reset) begin
      wr_addr <= '0;
      byte_idx <= '0;
      buffer <= '0;
      last_seen <= 1'b0;
      load_overflow <= 1'b0;
    end else begin
      if (state == L_IDLE && load_start) begin
        wr_addr <= '0;
        byte_idx <= '0;
        buffer <= '0;
        last_seen <= 1'b0;
      end
      if (accept) begin
        buffer[8*byte_idx +: 8] <= load_byte;
        byte_idx <= byte_idx + 2'd1;
        last_seen <= load_last;
      end
      if (state == L_WRITE) begin
        buffer <= '0;
        byte_idx <= '0;
        last_seen <= 1'b0;
        if (wr_in_range) wr_addr <= wr_addr + 1'b1;
        else load_overflow <= 1'b1;
      end
    end
  always_ff @(posedge CLK)
    if (!reset && state == L_WRITE && wr_in_range) mem[wr_addr[ADDR_BITS-1:0]] <= buffer;
  always_ff @(posedge CLK)
    if (reset) begin
      memory_read_data <= '0;
      read_out_of_range <= 1'b0;
    end else if (memory_read_strobe) begin
      memory_read_data <= rd_in_range ? mem[memory_address[ADDR_BITS-1:0]] : 32'd0;
      read_out_of_range <= read_out_of_range | !rd_in_range;
    end
endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: directed + randomized checks of program_memory against a
// word-level model of the loader (bytes packed little-endian, zero-padded, capped at WORDS).
module tb_program_memory;
  localparam int WORDS = 256;
  logic CLK = 1'b0, reset = 1'b1;
  logic [31:0] memory_address = '0;
  logic memory_read_strobe = 1'b0, load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0] load_byte = '0;
  logic [31:0] memory_read_data;
  logic load_ready, load_busy, read_out_of_range, load_overflow;
  logic [8:0] load_word_count;
  int checks = 0, errors = 0;
  logic [31:0] model_mem [WORDS];
  int model_count = 0;
  program_memory #(.WORDS(WORDS), .ADDR_BITS(8)) dut (
    .CLK(CLK), .reset(reset), .memory_address(memory_address),
    .memory_read_strobe(memory_read_strobe), .memory_read_data(memory_read_data),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_byte(load_byte), .load_ready(load_ready), .load_busy(load_busy),
    .load_word_count(load_word_count), .read_out_of_range(read_out_of_range),
    .load_overflow(load_overflow));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    memory_address = a;
    memory_read_strobe = 1'b1;
    tick();
    memory_read_strobe = 1'b0;
    chk(tag, memory_read_data, exp);
  endtask
  // Reference: each group of 4 bytes forms a little-endian word, short tail padded with zero
  task automatic model_load(input logic [7:0] q[$], input int first_words);
    int nw;
    nw = (q.size() + 3) / 4;
    if (first_words >= 0) nw = first_words;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      word = '0;
      for (int b = 0; b < 4; b++)
        if (4*w + b < q.size()) word = word | (32'(q[4*w+b]) << (8*b));
      if (w < WORDS) model_mem[w] = word;
    end
    model_count = nw > WORDS ? WORDS : nw;
  endtask
  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask
  task automatic feed(input logic [7:0] q[$], input bit last_on_end, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      int n;
      if (gaps && $urandom_range(3) == 0) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_byte = q[i];
      load_last = last_on_end && i == q.size() - 1;
      n = 0;
      while (!load_ready && n < 20) begin
        tick();
        n++;
      end
      if (!load_ready) chk("ready_timeout", load_ready, 1);
      tick();
    end
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (load_busy && n < 20) begin
      tick();
      n++;
    end
    chk("busy_drop", load_busy, 0);
  endtask
  task automatic random_bytes(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask
  initial begin
    logic [7:0] q[$];
    logic [10:1] rdy_seq;
    logic [31:0] old0;
    int k;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_data", memory_read_data, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_count", load_word_count, 0);
    chk("rst_oor", read_out_of_range, 0);
    chk("rst_ovf", load_overflow, 0);
    // Directed six-byte programme
    q = '{8'hB3, 8'h81, 8'h20, 8'h00, 8'h13, 8'h05};
    start();
    feed(q, 1, 0);
    chk("six_busy_in_write", load_busy, 1);
    chk("six_ready_in_write", load_ready, 0);
    tick();
    chk("six_busy_fall", load_busy, 0);
    chk("six_count", load_word_count, 2);
    model_load(q, -1);
    rd(0, 32'h002081B3, "six_mem0");
    rd(1, 32'h00000513, "six_mem1");
    // Data holds with strobe low even as the address moves
    rd(0, 32'h002081B3, "hold_n1");
    memory_address = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_n4", memory_read_data, 32'h002081B3);
    // Back-to-back strobes each return one word
    memory_address = 1;
    memory_read_strobe = 1'b1;
    tick();
    chk("b2b_first", memory_read_data, model_mem[1]);
    memory_address = 0;
    tick();
    memory_read_strobe = 1'b0;
    chk("b2b_second", memory_read_data, model_mem[0]);
    // Continuous valid: ready drops only in the two write bubbles
    random_bytes(q, 8);
    start();
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      bit acc;
      load_valid = k < 8;
      load_byte = k < 8 ? q[k] : 8'h00;
      load_last = k == 7;
      rdy_seq[c] = load_ready;
      acc = load_valid && load_ready;
      tick();
      if (acc) k++;
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    chk("cont_ready_pattern", rdy_seq, 10'b0111101111);
    chk("cont_bytes_taken", k, 8);
    chk("cont_busy", load_busy, 0);
    model_load(q, -1);
    chk("cont_count", load_word_count, model_count);
    rd(0, model_mem[0], "cont_mem0");
    rd(1, model_mem[1], "cont_mem1");
    // Random sessions with gaps and partial final words
    for (int s = 0; s < 6; s++) begin
      random_bytes(q, $urandom_range(1, 40));
      start();
      feed(q, 1, 1);
      wait_idle();
      model_load(q, -1);
      chk("rnd_count", load_word_count, model_count);
      for (int w = 0; w < model_count; w++) rd(w, model_mem[w], "rnd_mem");
    end
    // Read/write collision on index 0 returns the old word
    old0 = model_mem[0];
    random_bytes(q, 4);
    start();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_byte = q[i];
      load_last = i == 3;
      tick();
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    chk("col_busy", load_busy, 1);
    chk("col_ready", load_ready, 0);
    rd(0, old0, "col_old");
    model_load(q, -1);
    rd(0, model_mem[0], "col_new");
    chk("col_count", load_word_count, 1);
    // Out-of-range reads, full 32-bit compare
    rd(32'd256, 0, "oor_data");
    chk("oor_flag", read_out_of_range, 1);
    rd(32'h8000_0003, 0, "oor_hi_data");
    rd(0, model_mem[0], "oor_valid_read");
    chk("oor_sticky", read_out_of_range, 1);
    // 257 words into 256: last word discarded, overflow flagged, count saturates
    random_bytes(q, 4 * 257);
    start();
    feed(q, 1, 0);
    wait_idle();
    model_load(q, -1);
    chk("ovf_flag", load_overflow, 1);
    chk("ovf_count", load_word_count, WORDS);
    for (int w = 0; w < WORDS; w++) rd(w, model_mem[w], "ovf_mem");
    // Reset two bytes into word 3
    random_bytes(q, 14);
    start();
    feed(q, 0, 1);
    chk("mid_busy_before", load_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_ready", load_ready, 0);
    chk("mid_busy", load_busy, 0);
    chk("mid_count", load_word_count, 0);
    chk("mid_oor_clr", read_out_of_range, 0);
    chk("mid_ovf_clr", load_overflow, 0);
    model_load(q, 3);
    for (int w = 0; w < 5; w++) rd(w, model_mem[w], "mid_mem");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
